// File: rtl/des_key_sched_rev.sv
// Sequential DES key schedule: one 64-bit key in, sixteen 48-bit round subkeys out
// over valid/ready, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched_rev (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] key_in,
    input  logic        mode,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round_idx,
    output logic        subkey_last,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        busy
);

    typedef enum logic {IDLE, GEN} state_t;

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;

    logic [55:0] pc1_key;
    logic [55:0] cd_q;
    logic        one_step;
    logic        xfer;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // Parity bits (DES bits 8,16,...,64) take no part in the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    // PC-1: DES bit n of the key sits at key_in[64-n].
    assign pc1_key = {
        key_in[7],  key_in[15], key_in[23], key_in[31], key_in[39], key_in[47], key_in[55],
        key_in[63], key_in[6],  key_in[14], key_in[22], key_in[30], key_in[38], key_in[46],
        key_in[54], key_in[62], key_in[5],  key_in[13], key_in[21], key_in[29], key_in[37],
        key_in[45], key_in[53], key_in[61], key_in[4],  key_in[12], key_in[20], key_in[28],
        key_in[1],  key_in[9],  key_in[17], key_in[25], key_in[33], key_in[41], key_in[49],
        key_in[57], key_in[2],  key_in[10], key_in[18], key_in[26], key_in[34], key_in[42],
        key_in[50], key_in[58], key_in[3],  key_in[11], key_in[19], key_in[27], key_in[35],
        key_in[43], key_in[51], key_in[59], key_in[36], key_in[44], key_in[52], key_in[60]
    };

    // PC-2 over {C,D}: bit n of the 56-bit pair sits at cd_q[56-n].
    assign cd_q = {c_q, d_q};
    assign subkey = {
        cd_q[42], cd_q[39], cd_q[45], cd_q[32], cd_q[55], cd_q[51], cd_q[53], cd_q[28],
        cd_q[41], cd_q[50], cd_q[35], cd_q[46], cd_q[33], cd_q[37], cd_q[44], cd_q[52],
        cd_q[30], cd_q[48], cd_q[40], cd_q[49], cd_q[29], cd_q[36], cd_q[43], cd_q[54],
        cd_q[15], cd_q[4],  cd_q[25], cd_q[19], cd_q[9],  cd_q[1],  cd_q[26], cd_q[16],
        cd_q[5],  cd_q[11], cd_q[23], cd_q[8],  cd_q[12], cd_q[7],  cd_q[17], cd_q[0],
        cd_q[22], cd_q[3],  cd_q[10], cd_q[14], cd_q[6],  cd_q[20], cd_q[27], cd_q[24]
    };

    // Single-bit steps fall after the 1st, 8th and 15th emitted subkey in either direction.
    assign one_step = (cnt_q == 4'd0) || (cnt_q == 4'd7) || (cnt_q == 4'd14);
    assign xfer     = subkey_valid && subkey_ready;

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    dir_d   = mode;
                    cnt_d   = 4'd0;
                    state_d = GEN;
                    if (mode) begin
                        c_d = pc1_key[55:28];
                        d_d = pc1_key[27:0];
                    end else begin
                        c_d = rotl(pc1_key[55:28], 1'b1);
                        d_d = rotl(pc1_key[27:0], 1'b1);
                    end
                end
            end
            GEN: begin
                if (xfer) begin
                    if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (dir_q) begin
                            c_d = rotr(c_q, one_step);
                            d_d = rotr(d_q, one_step);
                        end else begin
                            c_d = rotl(c_q, one_step);
                            d_d = rotl(d_q, one_step);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign key_ready    = (state_q == IDLE);
    assign busy         = (state_q == GEN);
    assign subkey_valid = (state_q == GEN);
    assign round_idx    = dir_q ? (4'd15 - cnt_q) : cnt_q;
    assign subkey_last  = (state_q == GEN) && (cnt_q == 4'd15);

endmodule

// File: doc/des_key_sched_rev.md
Name: des_key_sched_rev

Overview:
Sequential DES key schedule for the decrypt direction of the pipelined DES datapath. It also supports encrypt order.
- Accepts one 64-bit key and emits the sixteen 48-bit round subkeys, one per handshake, over a valid/ready interface.
- Decrypt mode emits K16 down to K1 using right rotations; encrypt mode emits K1 up to K16 using left rotations.
- Feeds the round stages that drive the S-box substitution layer.

Parameters:
none (DES constants fixed: PC-1, PC-2, shift schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for rounds 1..16)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
key_in  in  64  DES key; DES bit 1 = key_in[63]; parity bits (8,16,...,64) ignored
mode  in  1  sampled with the key: 0 = encrypt order (K1..K16), 1 = decrypt order (K16..K1)
key_valid  in  1  key_in/mode valid
key_ready  out  1  high only in IDLE
subkey  out  48  current round subkey; PC-2 bit 1 = subkey[47]
round_idx  out  4  DES round number of subkey, 1..16 encoded as 0..15
subkey_last  out  1  high with the 16th subkey of a key
subkey_valid  out  1  subkey/round_idx/subkey_last valid
subkey_ready  in  1  consumer accepts subkey
busy  out  1  high in GEN

Behaviour:
- Reset: state = IDLE, cnt = 0, C/D = 0, dir = 0.
  - Outputs after reset: key_ready = 1, subkey_valid = 0, busy = 0, subkey_last = 0, round_idx = 0, subkey = PC2(0) = 0.
- States: IDLE and GEN.
  - Registers: 28-bit C, 28-bit D, 4-bit cnt, dir flag.
- IDLE:
  - Key accept: key_valid & key_ready in cycle T.
  - Load {C,D} = PC1(key_in) and dir = mode.
  - If mode = 0, C and D are also rotated left by 1 at load, giving C1/D1.
  - If mode = 1, there is no rotation: C16 = C0.
  - Set cnt = 0 and go to GEN. subkey_valid rises in cycle T+1 (1-cycle latency).
- GEN:
  - subkey = PC2({C,D}), combinational from registers only, with no path from key_in.
  - subkey_valid = 1.
  - round_idx = cnt when dir = 0, else 15 - cnt.
  - subkey_last = (cnt == 15).
- Subkey transfer (subkey_valid & subkey_ready):
  - If cnt == 15: go to IDLE. key_ready rises the next cycle; C/D contents are don't-care.
  - Otherwise: cnt++.
    - Encrypt: rotate C and D left by shift[round r+1], where r is the current round 1..16.
    - Decrypt: rotate C and D right by shift[current round r].
    - Example: after K16 rotate right 1, after K15 rotate right 2, ..., after K2 rotate right 1.
- Backpressure: while subkey_valid & !subkey_ready, subkey, round_idx, subkey_last and the registers hold stable.
- key_valid is ignored in GEN. key_in and mode may change freely after acceptance.
  - Minimum 17 cycles per key: 16 transfers + 1 bubble in IDLE; there is no back-to-back overlap.
- rst mid-GEN: return to IDLE next cycle, subkey_valid = 0 and the partial sequence is discarded. rst has priority over every handshake in the same cycle.
- Rotations are 28-bit circular, applied to C and D independently.
  - The total of all 16 shifts is 28, so decrypt K1 is reached from C0 by the right-rotation chain.

Test Plan:
1. Encrypt, key 0x133457799BBCDFF1, mode = 0, subkey_ready tied high:
   - subkey_valid at T+1.
   - Subkeys in order: K1 = 0x1B02EFFC7072, K2 = 0x79AED9DBC9E5, ..., K15 = 0xBF918D3D3F0A, K16 = 0xCB3D8B0E17F5.
   - round_idx runs 0..15; subkey_last only on the 16th subkey; key_ready = 1 the cycle after.
2. Decrypt, same key, mode = 1:
   - Subkeys in order: 0xCB3D8B0E17F5, 0xBF918D3D3F0A, ..., 0x79AED9DBC9E5, 0x1B02EFFC7072.
   - round_idx runs 15..0.
   - Full 16-value sequence must equal scenario 1 reversed, checked against the reference model.
3. Random subkey_ready stalls in decrypt:
   - subkey and round_idx stable during every stall.
   - Exactly 16 transfers, with values matching scenario 2.
4. Pulse key_valid with a different key during GEN:
   - Ignored; key_ready = 0.
   - Sequence of the first key is uncorrupted.
5. Assert rst for 1 cycle after the 5th transfer:
   - Next cycle subkey_valid = 0, key_ready = 1.
   - Newly loaded key 0x0000000000000000 yields all 16 subkeys = 0x000000000000.
6. Parity-bit independence:
   - Key 0x133457799BBCDFF1 XOR 0x0101010101010101 produces subkeys identical to scenario 1.
